// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// forward_hazard_unit
//   EX-stage operand bypass select and load-use stall generation.
//   Revision: 1.0
// ============================================================================
module forward_hazard_unit #(
  parameter int REG_W    = 3,
  parameter int DATA_W   = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IdValid,
  input  logic [REG_W-1:0]  IdRs,
  input  logic [REG_W-1:0]  IdRt,
  input  logic              IdUsesRs,
  input  logic              IdUsesRt,
  input  logic              IdWrites,
  input  logic [REG_W-1:0]  IdRd,
  input  logic              IdIsLoad,
  input  logic              DivStall,
  input  logic [DATA_W-1:0] MemResult,
  input  logic [DATA_W-1:0] WbResult,
  output logic              ForwardRs,
  output logic              ForwardRt,
  output logic [DATA_W-1:0] RsForwarding,
  output logic [DATA_W-1:0] RtForwarding,
  output logic              Stall
);

  localparam logic [1:0] c_SEL_NONE = 2'd0;
  localparam logic [1:0] c_SEL_MEM  = 2'd1;
  localparam logic [1:0] c_SEL_WB   = 2'd2;
  localparam logic [1:0] c_SEL_RET  = 2'd3;

  logic              ex_valid_q, ex_writes_q, ex_load_q;
  logic [REG_W-1:0]  ex_rd_q;
  logic              mem_valid_q, mem_writes_q, mem_load_q;
  logic [REG_W-1:0]  mem_rd_q;
  logic              wb_valid_q, wb_writes_q;
  logic [REG_W-1:0]  wb_rd_q;
  logic              ret_valid_q;
  logic [DATA_W-1:0] ret_data_q;
  logic [1:0]        sel_rs_q, sel_rt_q;
  logic [1:0]        sel_rs_d, sel_rt_d;

  logic w_lu;
  logic w_take;

  function automatic logic hit(input logic v, input logic w,
                               input logic [REG_W-1:0] rd,
                               input logic [REG_W-1:0] op,
                               input logic used);
    return v & w & used & (rd == op) & ~(ZERO_REG & (op == '0));
  endfunction

  // Slots are checked as they will be once the ID instruction reaches EX.
  function automatic logic [1:0] pick(input logic [REG_W-1:0] op, input logic used);
    if (hit(ex_valid_q, ex_writes_q, ex_rd_q, op, used))
      return c_SEL_MEM;
    else if (hit(mem_valid_q, mem_writes_q, mem_rd_q, op, used))
      return c_SEL_WB;
    else if (hit(wb_valid_q, wb_writes_q, wb_rd_q, op, used))
      return c_SEL_RET;
    return c_SEL_NONE;
  endfunction

  function automatic logic [DATA_W-1:0] bypass(input logic [1:0] sel);
    case (sel)
      c_SEL_MEM: return MemResult;
      c_SEL_WB:  return WbResult;
      c_SEL_RET: return ret_valid_q ? ret_data_q : '0;
      default:   return '0;
    endcase
  endfunction

  assign w_lu = IdValid & ex_load_q &
                (hit(ex_valid_q, ex_writes_q, ex_rd_q, IdRs, IdUsesRs) |
                 hit(ex_valid_q, ex_writes_q, ex_rd_q, IdRt, IdUsesRt));
  assign Stall  = w_lu & ~DivStall;
  assign w_take = IdValid & ~w_lu;

  always_comb begin
    sel_rs_d = c_SEL_NONE;
    sel_rt_d = c_SEL_NONE;
    if (w_take) begin
      sel_rs_d = pick(IdRs, IdUsesRs);
      sel_rt_d = pick(IdRt, IdUsesRt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_writes_q  <= 1'b0;
      ex_load_q    <= 1'b0;
      ex_rd_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_writes_q <= 1'b0;
      mem_load_q   <= 1'b0;
      mem_rd_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_writes_q  <= 1'b0;
      wb_rd_q      <= '0;
      ret_valid_q  <= 1'b0;
      ret_data_q   <= '0;
      sel_rs_q     <= c_SEL_NONE;
      sel_rt_q     <= c_SEL_NONE;
    end else if (!DivStall) begin
      if (wb_valid_q && wb_writes_q) begin
        ret_valid_q <= 1'b1;
        ret_data_q  <= WbResult;
      end
      wb_valid_q   <= mem_valid_q;
      wb_writes_q  <= mem_writes_q;
      wb_rd_q      <= mem_rd_q;
      mem_valid_q  <= ex_valid_q;
      mem_writes_q <= ex_writes_q;
      mem_load_q   <= ex_load_q;
      mem_rd_q     <= ex_rd_q;
      ex_valid_q   <= w_take;
      ex_writes_q  <= w_take & IdWrites;
      ex_load_q    <= w_take & IdIsLoad;
      ex_rd_q      <= w_take ? IdRd : '0;
      sel_rs_q     <= sel_rs_d;
      sel_rt_q     <= sel_rt_d;
    end
  end

  // mem_load_q is kept for slot symmetry; a load is never bypassed from MEM.
  logic w_unused;
  assign w_unused = mem_load_q;

  assign ForwardRs    = (sel_rs_q != c_SEL_NONE);
  assign ForwardRt    = (sel_rt_q != c_SEL_NONE);
  assign RsForwarding = bypass(sel_rs_q);
  assign RtForwarding = bypass(sel_rt_q);

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_forward_hazard_unit
//   Directed plus random checks against an instruction-history model.
//   Revision: 1.0
// ============================================================================
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IdValid = 1'b0, IdUsesRs = 1'b0, IdUsesRt = 1'b0;
  logic        IdWrites = 1'b0, IdIsLoad = 1'b0, DivStall = 1'b0;
  logic [2:0]  IdRs = '0, IdRt = '0, IdRd = '0;
  logic [15:0] MemResult = '0, WbResult = '0;
  logic        ForwardRs, ForwardRt, Stall;
  logic [15:0] RsForwarding, RtForwarding;

  forward_hazard_unit #(.REG_W(3), .DATA_W(16), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
    .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
    .IdWrites(IdWrites), .IdRd(IdRd), .IdIsLoad(IdIsLoad),
    .DivStall(DivStall), .MemResult(MemResult), .WbResult(WbResult),
    .ForwardRs(ForwardRs), .ForwardRt(ForwardRt),
    .RsForwarding(RsForwarding), .RtForwarding(RtForwarding),
    .Stall(Stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit v, urs, urt, wr, ld;
    bit [2:0] rs, rt, rd;
    bit [15:0] res;
  } ins_t;

  // One entry per instruction (or bubble) that has entered EX since reset.
  typedef struct {
    bit v, wr, ld;
    bit [2:0] rd;
    bit [15:0] res;
    int srs, srt;
  } ent_t;

  ent_t hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(bit v, bit [2:0] rd, bit [2:0] rs, bit [2:0] rt,
                              bit urs, bit urt, bit wr, bit ld, bit [15:0] res);
    ins_t i;
    i.v = v; i.rd = rd; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.wr = wr; i.ld = ld; i.res = res;
    return i;
  endfunction

  function automatic ins_t alu(bit [2:0] rd, bit [2:0] rs, bit [2:0] rt, bit [15:0] res);
    return mk(1, rd, rs, rt, 1, 1, 1, 0, res);
  endfunction

  function automatic ins_t lw(bit [2:0] rd, bit [2:0] rs, bit [15:0] res);
    return mk(1, rd, rs, 3'd0, 1, 0, 1, 1, res);
  endfunction

  // Youngest writer of r among the three instructions issued just before.
  function automatic int find_src(bit [2:0] r, bit used);
    if (!used || r == 3'd0) return -1;
    for (int d = 0; d < 3; d++) begin
      int k;
      k = hist.size() - 1 - d;
      if (k < 0) break;
      if (hist[k].v && hist[k].wr && hist[k].rd == r) return k;
    end
    return -1;
  endfunction

  function automatic bit exp_stall(ins_t i, bit div);
    int n;
    bit m;
    n = hist.size();
    if (div || !i.v || n == 0) return 1'b0;
    if (!(hist[n-1].v && hist[n-1].ld && hist[n-1].wr) || hist[n-1].rd == 3'd0) return 1'b0;
    m = (i.urs && i.rs == hist[n-1].rd) || (i.urt && i.rt == hist[n-1].rd);
    return m;
  endfunction

  // A real pipeline presents each instruction's own result in MEM/WB.
  task automatic drive(ins_t i, bit div, bit r);
    int n;
    n = hist.size();
    IdValid = i.v; IdRs = i.rs; IdRt = i.rt; IdUsesRs = i.urs; IdUsesRt = i.urt;
    IdWrites = i.wr; IdRd = i.rd; IdIsLoad = i.ld; DivStall = div; rst = r;
    MemResult = (n >= 2 && hist[n-2].v && hist[n-2].wr && !hist[n-2].ld) ?
                hist[n-2].res : 16'($urandom);
    WbResult  = (n >= 3 && hist[n-3].v && hist[n-3].wr) ? hist[n-3].res : 16'($urandom);
  endtask

  task automatic check_fwd(input string tag);
    int n, srs, srt;
    n = hist.size();
    srs = (n > 0) ? hist[n-1].srs : -1;
    srt = (n > 0) ? hist[n-1].srt : -1;
    check({tag, ".fwd_rs"}, ForwardRs, srs >= 0);
    check({tag, ".fwd_rt"}, ForwardRt, srt >= 0);
    check({tag, ".rs_data"}, RsForwarding, (srs >= 0) ? hist[srs].res : 16'h0);
    check({tag, ".rt_data"}, RtForwarding, (srt >= 0) ? hist[srt].res : 16'h0);
  endtask

  task automatic cycle(ins_t i, bit div, bit r, output bit consumed);
    bit st;
    ent_t e;
    drive(i, div, r);
    #2;
    st = exp_stall(i, div);
    if (!r) begin
      check("stall", Stall, st);
      check_fwd("model");
    end
    consumed = !r && !div && !st;
    @(posedge clk);
    if (r) begin
      hist.delete();
    end else if (!div) begin
      e.v = consumed && i.v;
      e.wr = e.v && i.wr;
      e.ld = e.v && i.ld;
      e.rd = i.rd;
      e.res = i.res;
      e.srs = e.v ? find_src(i.rs, i.urs) : -1;
      e.srt = e.v ? find_src(i.rt, i.urt) : -1;
      hist.push_back(e);
    end
    #1;
  endtask

  task automatic issue(ins_t i);
    bit c;
    int k;
    k = 0;
    do begin
      cycle(i, 1'b0, 1'b0, c);
      k++;
    end while (!c && k < 4);
    check("issue_bound", c, 1'b1);
  endtask

  task automatic peek();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t idle, i;
    bit c;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    cycle(idle, 1'b0, 1'b1, c);
    cycle(idle, 1'b1, 1'b1, c);
    peek();
    check("rst.fwd_rs", ForwardRs, 1'b0);
    check("rst.fwd_rt", ForwardRt, 1'b0);
    check("rst.rs_data", RsForwarding, 16'h0);
    check("rst.stall", Stall, 1'b0);

    // Back-to-back dependency: MEM bypass.
    issue(alu(3'd2, 3'd1, 3'd1, 16'h1234));
    issue(alu(3'd3, 3'd2, 3'd1, 16'h0001));
    peek();
    check("mem.fwd_rs", ForwardRs, 1'b1);
    check("mem.rs_data", RsForwarding, 16'h1234);
    check("mem.fwd_rt", ForwardRt, 1'b0);

    // Distance 2: WB bypass.
    issue(alu(3'd4, 3'd0, 3'd0, 16'h00AA));
    issue(alu(3'd1, 3'd0, 3'd0, 16'h5555));
    issue(alu(3'd5, 3'd4, 3'd0, 16'h0002));
    peek();
    check("wb.fwd_rs", ForwardRs, 1'b1);
    check("wb.rs_data", RsForwarding, 16'h00AA);

    // Distance 3: RET bypass while WbResult carries an unrelated value.
    issue(alu(3'd4, 3'd0, 3'd0, 16'h00AA));
    issue(alu(3'd1, 3'd0, 3'd0, 16'h5555));
    issue(alu(3'd7, 3'd0, 3'd0, 16'h7777));
    issue(alu(3'd5, 3'd4, 3'd0, 16'h0003));
    peek();
    check("ret.fwd_rs", ForwardRs, 1'b1);
    check("ret.rs_data", RsForwarding, 16'h00AA);

    // Load-use: one stall cycle, bubble, then WB bypass of load data.
    issue(lw(3'd5, 3'd0, 16'hBEEF));
    cycle(alu(3'd6, 3'd5, 3'd0, 16'h0006), 1'b0, 1'b0, c);
    check("lu.held", c, 1'b0);
    peek();
    check("lu.bubble_rs", ForwardRs, 1'b0);
    check("lu.bubble_rt", ForwardRt, 1'b0);
    cycle(alu(3'd6, 3'd5, 3'd0, 16'h0006), 1'b0, 1'b0, c);
    check("lu.go", c, 1'b1);
    peek();
    check("lu.fwd_rs", ForwardRs, 1'b1);
    check("lu.rs_data", RsForwarding, 16'hBEEF);

    // Divider hold with a MEM-select consumer in EX and a pending load-use.
    issue(alu(3'd2, 3'd0, 3'd0, 16'h1234));
    issue(lw(3'd5, 3'd2, 16'hC0DE));
    for (int k = 0; k < 5; k++) begin
      cycle(alu(3'd6, 3'd5, 3'd0, 16'h0606), 1'b1, 1'b0, c);
      peek();
      check("div.fwd_rs", ForwardRs, 1'b1);
      check("div.rs_data", RsForwarding, 16'h1234);
      check("div.stall", Stall, 1'b0);
    end
    drive(alu(3'd6, 3'd5, 3'd0, 16'h0606), 1'b0, 1'b0);
    #1;
    check("div.release_stall", Stall, 1'b1);
    cycle(alu(3'd6, 3'd5, 3'd0, 16'h0606), 1'b0, 1'b0, c);
    cycle(alu(3'd6, 3'd5, 3'd0, 16'h0606), 1'b0, 1'b0, c);
    check("div.single_stall", c, 1'b1);

    // r0 is never forwarded.
    issue(alu(3'd0, 3'd1, 3'd1, 16'hDEAD));
    issue(alu(3'd3, 3'd0, 3'd0, 16'h0003));
    peek();
    check("r0.fwd_rs", ForwardRs, 1'b0);

    // Writers of r6 in MEM, WB and RET: youngest wins for both operands.
    issue(alu(3'd6, 3'd0, 3'd0, 16'h6003));
    issue(alu(3'd6, 3'd0, 3'd0, 16'h6002));
    issue(alu(3'd6, 3'd0, 3'd0, 16'h6001));
    issue(alu(3'd1, 3'd6, 3'd6, 16'h0011));
    peek();
    check("prio.rs_data", RsForwarding, 16'h6001);
    check("prio.rt_data", RtForwarding, 16'h6001);

    // Reset while EX selects WB and ID is load-use stalled.
    issue(alu(3'd4, 3'd0, 3'd0, 16'h4444));
    issue(alu(3'd7, 3'd0, 3'd0, 16'h7070));
    issue(lw(3'd5, 3'd4, 16'h5555));
    drive(alu(3'd1, 3'd5, 3'd0, 16'h0101), 1'b0, 1'b0);
    #1;
    check("rstmid.pre_stall", Stall, 1'b1);
    cycle(alu(3'd1, 3'd5, 3'd0, 16'h0101), 1'b0, 1'b1, c);
    drive(alu(3'd1, 3'd5, 3'd0, 16'h0101), 1'b0, 1'b0);
    #1;
    check("rstmid.fwd_rs", ForwardRs, 1'b0);
    check("rstmid.fwd_rt", ForwardRt, 1'b0);
    check("rstmid.rs_data", RsForwarding, 16'h0);
    check("rstmid.stall", Stall, 1'b0);
    issue(alu(3'd1, 3'd4, 3'd4, 16'h0101));
    peek();
    check("rstmid.no_ret", ForwardRs, 1'b0);

    // Random traffic against the history model.
    for (int it = 0; it < 400; it++) begin
      int k;
      case ($urandom_range(0, 9))
        0:       i = idle;
        1, 2, 3: i = lw(3'($urandom), 3'($urandom), 16'($urandom));
        default: i = mk(1, 3'($urandom), 3'($urandom), 3'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom), 0, 16'($urandom));
      endcase
      k = 0;
      do begin
        cycle(i, ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0), c);
        k++;
      end while (!c && k < 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Producer side of the Execute stage's operand-bypass interface: generates ForwardRs/ForwardRt and RsForwarding/RtForwarding for the instruction in EX, and raises Stall on load-use hazards.
- Tracks destination registers of in-flight instructions through its own EX/MEM/WB/RET slot pipeline.
- Freezes with the pipeline whenever the ALU divider asserts DivStall.

Parameters:
- REG_W, 3, register-address width (8 architectural registers).
- DATA_W, 16, datapath width.
- ZERO_REG, 1, when 1, r0 is hard-wired zero and never forwarded.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IdValid  in  1  ID holds a real instruction
- IdRs  in  REG_W  ID source register A
- IdRt  in  REG_W  ID source register B
- IdUsesRs  in  1  ID instruction reads Rs
- IdUsesRt  in  1  ID instruction reads Rt
- IdWrites  in  1  ID instruction writes a register
- IdRd  in  REG_W  ID destination register
- IdIsLoad  in  1  ID instruction is a memory load
- DivStall  in  1  divider busy; whole pipeline holds
- MemResult  in  DATA_W  ALU result of the instruction in MEM
- WbResult  in  DATA_W  final result (ALU or load data) of the instruction in WB
- ForwardRs  out  1  EX uses RsForwarding instead of DataOut1
- ForwardRt  out  1  EX uses RtForwarding instead of DataOut2
- RsForwarding  out  DATA_W  bypass value for Rs
- RtForwarding  out  DATA_W  bypass value for Rt
- Stall  out  1  hold PC and IF/ID, inject bubble into EX

Behaviour:
- Slots: EX, MEM and WB each hold {valid, writes, rd, isload}. RET holds {valid, rd, data} of the last retired writer; RET exists because the register file is not write-through.
- Reset, on any clk edge with rst=1:
  - all slots invalid; RET data = 0.
  - ForwardRs, ForwardRt, Stall = 0; RsForwarding, RtForwarding = 0.
  - rst overrides DivStall and any in-progress hazard.
- Load-use detection (combinational):
  - LU = IdValid & EX.valid & EX.isload & EX.writes & (EX.rd matches a used IdRs/IdRt).
  - When ZERO_REG=1, a match on rd=0 does not count.
  - Stall = LU & ~DivStall.
- Advance (posedge, rst=0, DivStall=0):
  - RET <= WB if WB.valid & WB.writes, capturing WbResult; otherwise RET holds.
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields, or an invalid bubble if Stall=1 or IdValid=0.
- Hold (DivStall=1): every slot, RET, and every forward select register holds its value. Stall=0.
- Forward select: a 2-bit code per operand (NONE/MEM/WB/RET), registered on advance.
  - Computed from ID Rs/Rt against the slots the instruction will see once it is in EX: current EX (becomes MEM), current MEM (becomes WB), current WB (becomes RET).
  - A slot matches if valid, writes, rd equals the operand, the operand is used, and it is not the r0 exception.
  - Priority: youngest wins, MEM > WB > RET.
  - A bubble entering EX gets NONE.
- Output mux (combinational from the registered selects):
  - ForwardRs = (sel != NONE).
  - RsForwarding = MemResult, WbResult, RET.data, or 0 for NONE. Rt is identical.
- Invariant: MEM is never selected for a load; the one-cycle load-use stall guarantees the load is in WB when its consumer reaches EX.
- Latency: select decision is 1 cycle (ID to EX); data path is 0 cycles.
- Simultaneous events:
  - DivStall with LU: DivStall wins. LU is re-evaluated after release, and Stall then lasts exactly one advancing cycle.
  - Rs and Rt matching different slots are resolved independently.
  - Rs == Rt gives the same select for both operands.
- Reset mid-stall or mid-divide: all selects return to NONE the next cycle, and no stale RET value is forwarded.

Test Plan:
- Back-to-back ALU dependency: add r2 then sub r3,r2,r1 -> in the sub's EX cycle, ForwardRs=1 and RsForwarding=MemResult (drive 16'h1234, expect 16'h1234); ForwardRt=0.
- Distance 2 and 3: producer r4=16'h00AA, then one independent instruction, then a consumer -> select WB with value 16'h00AA. Insert two independent instructions instead -> select RET with value 16'h00AA from the RET register while WbResult is driven to garbage.
- Load-use: load r5 followed by a use of r5 -> Stall=1 for exactly 1 cycle and EX gets a bubble (both selects NONE). The next cycle, the consumer in EX gets ForwardRs=1 from WB (WbResult=16'hBEEF).
- DivStall hold: assert DivStall for 5 cycles while a consumer with select MEM sits in EX -> ForwardRs stays 1 throughout, no slot shifts, Stall=0. Concurrent LU asserts Stall only on the first cycle after release.
- r0 and priority: writes to r0 followed by a read of r0 -> ForwardRs=0. Writers of r6 in MEM, WB and RET simultaneously -> MEM value selected.
- Reset mid-sequence: rst pulse while select is WB and Stall=1 -> the next cycle, all outputs are 0, and the RET data is not forwarded to a subsequent r-matching read.
